// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the PC sequencer and the datapath/icache side.
// Optional perf counters appear only when PC_SEQ_PERF_EN is defined.
interface pc_sequencer_if #(
  parameter int unsigned WORD_W = 32
);
  logic [WORD_W-1:0] PC;
  logic [WORD_W-1:0] npc;
  logic              ihit;
  logic              stall;
  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_target;
  logic              halt;
  logic              pcEN;
  logic [WORD_W-1:0] newpc;
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              fetch_valid;
  logic              flush;
  logic              halted;
`ifdef PC_SEQ_PERF_EN
  logic [31:0]       fetch_stall_cnt;
  logic [31:0]       redirect_cnt;
`endif

  modport slave (
    input  PC, npc, ihit, stall, redirect_valid, redirect_target, halt,
    output pcEN, newpc, imemREN, imemaddr, fetch_valid, flush, halted
`ifdef PC_SEQ_PERF_EN
    , output fetch_stall_cnt, redirect_cnt
`endif
  );

  modport master (
    output PC, npc, ihit, stall, redirect_valid, redirect_target, halt,
    input  pcEN, newpc, imemREN, imemaddr, fetch_valid, flush, halted
`ifdef PC_SEQ_PERF_EN
    , input fetch_stall_cnt, redirect_cnt
`endif
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC / instruction-fetch sequencer: BOOT -> FETCH <-> DRAIN, sticky HALT.
// Define PC_SEQ_PERF_EN to add saturating fetch-stall and redirect counters.
module pc_sequencer #(
  parameter int unsigned          WORD_W   = 32,
  parameter logic [WORD_W-1:0]    RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          nRST,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, HALT} state_t;

  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_pend_target, w_pend_nxt;
  logic [WORD_W-1:0] w_redir_tgt;

  assign w_redir_tgt = bus.redirect_target & ~WORD_W'(3);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state       <= BOOT;
      r_pend_target <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pend_target <= w_pend_nxt;
    end
  end

  // Outputs are gated by nRST so reset values appear while reset is held,
  // even though the state register already sits in BOOT.
  always_comb begin
    w_state_nxt     = r_state;
    w_pend_nxt      = r_pend_target;
    bus.pcEN        = 1'b0;
    bus.newpc       = RESET_PC;
    bus.imemREN     = 1'b0;
    bus.imemaddr    = '0;
    bus.fetch_valid = 1'b0;
    bus.flush       = 1'b0;
    bus.halted      = 1'b0;
    if (nRST) begin
      unique case (r_state)
        BOOT: begin
          bus.pcEN    = 1'b1;
          bus.newpc   = RESET_PC;
          w_state_nxt = FETCH;
        end
        FETCH: begin
          bus.imemREN  = 1'b1;
          bus.imemaddr = bus.PC;
          if (bus.halt) begin
            bus.imemREN = 1'b0;
            w_state_nxt = HALT;
          end else if (bus.redirect_valid) begin
            bus.flush = 1'b1;
            if (bus.ihit) begin
              bus.pcEN  = 1'b1;
              bus.newpc = w_redir_tgt;
            end else begin
              w_pend_nxt  = w_redir_tgt;
              w_state_nxt = DRAIN;
            end
          end else if (bus.ihit && !bus.stall) begin
            bus.pcEN        = 1'b1;
            bus.newpc       = bus.npc;
            bus.fetch_valid = 1'b1;
          end
        end
        DRAIN: begin
          bus.imemREN  = 1'b1;
          bus.imemaddr = bus.PC;
          if (bus.halt) begin
            w_state_nxt = HALT;
          end else begin
            if (bus.redirect_valid) begin
              bus.flush  = 1'b1;
              w_pend_nxt = w_redir_tgt;
            end
            if (bus.ihit) begin
              bus.pcEN    = 1'b1;
              bus.newpc   = bus.redirect_valid ? w_redir_tgt : r_pend_target;
              w_state_nxt = FETCH;
            end
          end
        end
        HALT: begin
          bus.halted = 1'b1;
        end
        default: w_state_nxt = BOOT;
      endcase
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic [31:0] r_fetch_stall_cnt;
  logic [31:0] r_redirect_cnt;
  logic        w_miss;

  assign w_miss = bus.imemREN & ~bus.ihit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fetch_stall_cnt <= '0;
      r_redirect_cnt    <= '0;
    end else if (r_state != HALT) begin
      if (w_miss && (r_fetch_stall_cnt != '1))
        r_fetch_stall_cnt <= r_fetch_stall_cnt + 32'd1;
      if (bus.flush && (r_redirect_cnt != '1))
        r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  assign bus.fetch_stall_cnt = r_fetch_stall_cnt;
  assign bus.redirect_cnt    = r_redirect_cnt;
`endif

endmodule
